// File: rtl/fft_pkg.sv
// Shared types, constants and rounding helper for the radix-2 FFT datapath.
package fft_pkg;

    localparam int FFT_DW           = 16;
    localparam int FFT_CR_STAGE_NUM = 10;

    // Half-LSB rounding constant for the default CORDIC stage count.
    localparam logic signed [63:0] CR_ROUND = 64'sd1 <<< (FFT_CR_STAGE_NUM - 1);

    // Complex container; fields are wide enough for any DW+2 <= 32 value.
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx_t;

    // Round half up, then arithmetic shift right by sh.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                       input int                 sh);
        logic signed [63:0] rnd;
        rnd = (sh == FFT_CR_STAGE_NUM) ? CR_ROUND : (64'sd1 <<< (sh - 1));
        return (v + rnd) >>> sh;
    endfunction

endpackage

// File: rtl/fft_cmul.sv
// Complex multiply W*B with W = c - j*s, two register stages sharing one advance enable.
module fft_cmul
    import fft_pkg::*;
#(
    parameter int DW           = FFT_DW,
    parameter int CR_STAGE_NUM = FFT_CR_STAGE_NUM,
    parameter int TW           = CR_STAGE_NUM + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic        [TW-1:0] cos,
    input  logic        [TW-1:0] sin,
    input  logic                 cos_sign,
    output logic signed [DW:0]   wb_re,
    output logic signed [DW:0]   wb_im
);

    localparam int PW = DW + TW + 1;

    logic signed [TW:0]   c_s;
    logic signed [TW:0]   s_s;
    logic signed [PW-1:0] c_x, s_x, bre_x, bim_x;
    logic signed [PW-1:0] m_cbre, m_sbim, m_cbim, m_sbre;

    // Signed twiddle terms, sign-extended to product width.
    always_comb begin
        c_s   = cos_sign ? -$signed({1'b0, cos}) : $signed({1'b0, cos});
        s_s   = $signed({1'b0, sin});
        c_x   = PW'(c_s);
        s_x   = PW'(s_s);
        bre_x = PW'(b_re);
        bim_x = PW'(b_im);
    end

    // S1: register the four partial products.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cbre <= '0;
            m_sbim <= '0;
            m_cbim <= '0;
            m_sbre <= '0;
        end else if (adv) begin
            m_cbre <= c_x * bre_x;
            m_sbim <= s_x * bim_x;
            m_cbim <= c_x * bim_x;
            m_sbre <= s_x * bre_x;
        end
    end

    // S2: combine, round half up, drop the twiddle scale; truncation is lossless since |W| <= 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_re <= '0;
            wb_im <= '0;
        end else if (adv) begin
            wb_re <= (DW+1)'(round_shift(64'(m_cbre) + 64'(m_sbim), CR_STAGE_NUM));
            wb_im <= (DW+1)'(round_shift(64'(m_cbim) - 64'(m_sbre), CR_STAGE_NUM));
        end
    end

endmodule

// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly, 3-stage pipeline with valid/ready flow control.
// Optional macro FFT_BFLY_SCALE_EN halves the outputs with round half up.
module fft_bfly_r2
    import fft_pkg::*;
#(
    parameter int DW           = FFT_DW,
    parameter int CR_STAGE_NUM = FFT_CR_STAGE_NUM,
    parameter int TW           = CR_STAGE_NUM + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic        [TW-1:0] cos,
    input  logic        [TW-1:0] sin,
    input  logic                 cos_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW+1:0] x0_re,
    output logic signed [DW+1:0] x0_im,
    output logic signed [DW+1:0] x1_re,
    output logic signed [DW+1:0] x1_im
);

    logic              adv;
    logic              v1, v2;
    cplx_t             a_d1, a_d2;
    cplx_t             s0, s1;
    logic signed [DW:0] wb_re, wb_im;

    // Whole pipeline advances unless a valid output is being held.
    always_comb begin
        adv      = out_ready | ~out_valid;
        in_ready = adv;
    end

    fft_cmul #(
        .DW           (DW),
        .CR_STAGE_NUM (CR_STAGE_NUM),
        .TW           (TW)
    ) u_cmul (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .b_re     (b_re),
        .b_im     (b_im),
        .cos      (cos),
        .sin      (sin),
        .cos_sign (cos_sign),
        .wb_re    (wb_re),
        .wb_im    (wb_im)
    );

    // Valid bits and operand A delayed to line up with the product path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            a_d1 <= '0;
            a_d2 <= '0;
        end else if (adv) begin
            v1      <= in_valid;
            v2      <= v1;
            a_d1.re <= 32'(a_re);
            a_d1.im <= 32'(a_im);
            a_d2    <= a_d1;
        end
    end

    // Butterfly sum and difference.
    always_comb begin
        s0.re = a_d2.re + 32'(wb_re);
        s0.im = a_d2.im + 32'(wb_im);
        s1.re = a_d2.re - 32'(wb_re);
        s1.im = a_d2.im - 32'(wb_im);
    end

    // S3: output registers, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x0_re     <= '0;
            x0_im     <= '0;
            x1_re     <= '0;
            x1_im     <= '0;
        end else if (adv) begin
            out_valid <= v2;
`ifdef FFT_BFLY_SCALE_EN
            x0_re     <= (DW+2)'((s0.re + 32'sd1) >>> 1);
            x0_im     <= (DW+2)'((s0.im + 32'sd1) >>> 1);
            x1_re     <= (DW+2)'((s1.re + 32'sd1) >>> 1);
            x1_im     <= (DW+2)'((s1.im + 32'sd1) >>> 1);
`else
            x0_re     <= (DW+2)'(s0.re);
            x0_im     <= (DW+2)'(s0.im);
            x1_re     <= (DW+2)'(s1.re);
            x1_im     <= (DW+2)'(s1.im);
`endif
        end
    end

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Self-checking bench for fft_bfly_r2: directed test-plan cases, backpressure,
// reset mid-flight and randomized flow against an arithmetic reference model.
module tb_fft_bfly_r2;

    localparam int DW  = 16;
    localparam int CRN = 10;
    localparam int TW  = CRN + 2;
    localparam longint SCALE = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic        [TW-1:0] cos = '0, sin = '0;
    logic                 cos_sign = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW+1:0] x0_re, x0_im, x1_re, x1_im;

    typedef struct {
        longint x0r, x0i, x1r, x1i;
    } res_t;

    res_t   exp_q[$];
    int     total = 0;
    int     bad   = 0;
    logic   in_xfer;

    fft_bfly_r2 #(
        .DW           (DW),
        .CR_STAGE_NUM (CRN),
        .TW           (TW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .cos       (cos),
        .sin       (sin),
        .cos_sign  (cos_sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0_re     (x0_re),
        .x0_im     (x0_im),
        .x1_re     (x1_re),
        .x1_im     (x1_im)
    );

    always #5 clk = ~clk;

    function automatic longint fdiv(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
        return q;
    endfunction

    // Reference: W*B with W = c - j s, rounded to nearest (half up), then A +/- WB.
    function automatic res_t model(input longint ar, input longint ai, input longint br,
                                   input longint bi, input longint cs, input longint sn,
                                   input logic sg);
        res_t   r;
        longint c, wr, wi;
        c  = sg ? -cs : cs;
        wr = fdiv(c * br + sn * bi + SCALE / 2, SCALE);
        wi = fdiv(c * bi - sn * br + SCALE / 2, SCALE);
        r.x0r = ar + wr;
        r.x0i = ai + wi;
        r.x1r = ar - wr;
        r.x1i = ai - wi;
`ifdef FFT_BFLY_SCALE_EN
        r.x0r = fdiv(r.x0r + 1, 2);
        r.x0i = fdiv(r.x0i + 1, 2);
        r.x1r = fdiv(r.x1r + 1, 2);
        r.x1i = fdiv(r.x1i + 1, 2);
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        res_t e;
        total++;
        assert (exp_q.size() != 0)
        else begin
            bad++;
            $error("FAIL sb_underflow observed=%0d expected=>0", exp_q.size());
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_x0_re", 64'(x0_re), e.x0r);
            chk("sb_x0_im", 64'(x0_im), e.x0i);
            chk("sb_x1_re", 64'(x1_re), e.x1r);
            chk("sb_x1_im", 64'(x1_im), e.x1i);
        end
    endtask

    // One clock: sample transfers at the falling edge, then advance past the rising edge.
    task automatic step();
        @(negedge clk);
        in_xfer = in_valid && in_ready;
        if (out_valid && out_ready) pop_check();
        if (in_xfer) exp_q.push_back(model(a_re, a_im, b_re, b_im, cos, sin, cos_sign));
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input longint ar, input longint ai, input longint br,
                            input longint bi, input longint cs, input longint sn,
                            input logic sg);
        in_valid = 1'b1;
        a_re     = DW'(ar);
        a_im     = DW'(ai);
        b_re     = DW'(br);
        b_im     = DW'(bi);
        cos      = TW'(cs);
        sin      = TW'(sn);
        cos_sign = sg;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Single beat through an idle pipe: checks latency, pulse width and values.
    task automatic single(input string tag, input longint cs, input longint sn, input logic sg,
                          input longint ar, input longint ai, input longint br, input longint bi,
                          input longint e0r, input longint e0i, input longint e1r, input longint e1i);
        set_beat(ar, ai, br, bi, cs, sn, sg);
        step();
        in_valid = 1'b0;
        step();
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        step();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_x0_re"}, 64'(x0_re), e0r);
        chk({tag, "_x0_im"}, 64'(x0_im), e0i);
        chk({tag, "_x1_re"}, 64'(x1_re), e1r);
        chk({tag, "_x1_im"}, 64'(x1_im), e1i);
        step();
        chk({tag, "_one_cycle"}, 64'(out_valid), 64'd0);
    endtask

    initial begin : main
        int   sent, stall;
        logic seen_first;
        logic signed [DW+1:0] s0r, s0i, s1r, s1i;
        longint bp_a[5];
        longint cs, smax;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_x0_re", 64'(x0_re), 64'd0);
        chk("rst_x1_im", 64'(x1_im), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Directed test-plan twiddles
`ifdef FFT_BFLY_SCALE_EN
        single("w_one", 1024, 0, 1'b0, 100, 50, 20, -10, 60, 20, 40, 30);
`else
        single("w_one", 1024, 0, 1'b0, 100, 50, 20, -10, 120, 40, 80, 60);
        single("w_mj", 0, 1024, 1'b0, 100, 50, 20, -10, 90, 30, 110, 70);
        single("w_m1", 1024, 0, 1'b1, 100, 50, 20, -10, 80, 60, 120, 40);
        single("round", 512, 0, 1'b0, 0, 0, 3, -3, 2, -1, -2, 1);
`endif
        // Extremes at the unit twiddle: WB must equal B exactly
        set_beat(-32768, 32767, -32768, 32767, 1024, 0, 1'b0);
        step();
        set_beat(32767, -32768, 32767, -32768, 1024, 0, 1'b1);
        step();
        drain();

        // Backpressure: 5 back-to-back beats, 4-cycle stall at first output
        bp_a = '{11, -22, 333, -4444, 5555};
        sent = 0;
        stall = 0;
        seen_first = 1'b0;
        s0r = '0; s0i = '0; s1r = '0; s1i = '0;
        for (int cyc = 0; cyc < 40 && (sent < 5 || exp_q.size() != 0); cyc++) begin
            if (sent < 5) set_beat(bp_a[sent], -bp_a[sent], 300 + sent, -7 * sent, 724, 724, sent[0]);
            else in_valid = 1'b0;
            out_ready = (stall == 0);
            step();
            if (in_xfer) sent++;
            if (stall > 0) begin
                stall--;
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready", 64'(in_ready), 64'd0);
                chk("bp_hold_x0_re", 64'(x0_re), 64'(s0r));
                chk("bp_hold_x0_im", 64'(x0_im), 64'(s0i));
                chk("bp_hold_x1_re", 64'(x1_re), 64'(s1r));
                chk("bp_hold_x1_im", 64'(x1_im), 64'(s1i));
            end else if (!seen_first && out_valid) begin
                seen_first = 1'b1;
                stall = 4;
                s0r = x0_re; s0i = x0_im; s1r = x1_re; s1i = x1_im;
            end
        end
        chk("bp_all_sent", 64'(sent), 64'd5);
        chk("bp_all_recv", 64'(exp_q.size()), 64'd0);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // Reset with beats in flight
        set_beat(1, 2, 3, 4, 1024, 0, 1'b0);
        step();
        set_beat(5, 6, 7, 8, 1024, 0, 1'b0);
        step();
        in_valid = 1'b0;
        step();
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_stale_out", 64'(out_valid), 64'd0);
        end
        set_beat(-300, 400, 1000, -2000, 0, 1024, 1'b0);
        step();
        drain();

        // Randomized flow with random on-circle-or-inside twiddles
        for (int cyc = 0; cyc < 400; cyc++) begin
            cs   = longint'($urandom_range(0, 1024));
            smax = longint'($floor($sqrt(real'(1048576 - cs * cs))));
            set_beat(longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))),
                     longint'($signed(DW'($urandom))), longint'($signed(DW'($urandom))),
                     cs, longint'($urandom_range(0, 32'(smax))), 1'($urandom));
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_bfly_r2.md
Name: fft_bfly_r2

Overview:
- Radix-2 DIT butterfly; sits directly downstream of cordic_rot and consumes its cos/sin/cos_sign twiddle outputs.
- Computes X0 = A + W·B and X1 = A − W·B, with W = c − j·s, c = ±cos/2^CR_STAGE_NUM and s = sin/2^CR_STAGE_NUM.
- Upstream control aligns A/B with the CORDIC latency, so data and twiddle arrive in the same cycle.
- 3-stage pipeline with valid/ready flow control.

Parameters:
DW, 16, input sample component width (signed two's complement)
CR_STAGE_NUM, 10, CORDIC stage count; twiddle scale is 2^CR_STAGE_NUM
TW, CR_STAGE_NUM+2, twiddle magnitude width (unsigned, max value 2^CR_STAGE_NUM)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat this cycle
a_re, a_im  in  DW  operand A, signed
b_re, b_im  in  DW  operand B, signed
cos  in  TW  twiddle cos magnitude
sin  in  TW  twiddle sin magnitude (angle in [0,π), so sin ≥ 0)
cos_sign  in  1  1 = cos negative
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
x0_re, x0_im, x1_re, x1_im  out  DW+2  results, signed

Behaviour:
- Reset (async assert, sync release): out_valid=0 and all x* outputs=0; the pipeline's valid bits are cleared.
- Advance: adv = out_ready | ~out_valid. All stages shift together when adv=1 and hold otherwise.
- in_ready = adv (combinational). A beat transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
- Latency: exactly 3 advancing cycles from input transfer to out_valid. Throughput is 1 beat/cycle when out_ready is held 1.
- S1: signed twiddle c = cos_sign ? −cos : cos, width TW+1. Register the four products c·b_re, sin·b_im, c·b_im, sin·b_re, each DW+TW+1 bits. Delay A alongside.
- S2:
  - p_re = c·b_re + sin·b_im; p_im = c·b_im − sin·b_re.
  - Round half up: add 2^(CR_STAGE_NUM−1), then shift right arithmetically by CR_STAGE_NUM.
  - Truncate to DW+1 bits; this is lossless because |W| ≤ 1 gives |W·B| ≤ √2·2^(DW−1).
- S3: x0 = A + WB, x1 = A − WB, sign-extended to DW+2 bits. No saturation is needed.
- Bubbles (in_valid=0 while adv=1) propagate as invalid stages. Output data registers update only when adv=1.
- Stall: while out_valid=1 and out_ready=0, outputs stay bit-stable and no beat is dropped or duplicated.
- Simultaneous output and input transfer in one cycle is allowed (full-rate flow).
- Reset mid-operation discards all in-flight beats; the first post-reset output is the first beat accepted after reset.
- Edge twiddle cos=2^CR_STAGE_NUM, sin=0 must yield exactly WB = B.

Optional Feature:
- Macro FFT_BFLY_SCALE_EN.
  - Defined: S3 results are halved with round half up (add 1, then shift right arithmetically by 1), then sign-extended to DW+2. This gives per-stage scaling for block-float-free FFT chains.
  - Undefined: results are unscaled as described above.
- Latency and ports are identical in both cases.

Decomposition:
- Package fft_pkg holds:
  - constant CR_ROUND = 1 << (CR_STAGE_NUM−1);
  - typedef cplx_t (struct of re/im);
  - a function that rounds and shifts a product sum.
- One sub-module, fft_cmul (S1–S2 complex multiply by conjugate-form twiddle, 2-cycle latency, shared adv enable). fft_bfly_r2 wraps it with the A delay line and the S3 add/sub.

Test Plan (CR_STAGE_NUM=10, DW=16, macro off unless stated):
- W=1 (cos=1024, sin=0, sign=0), A=(100,50), B=(20,−10) -> after 3 cycles x0=(120,40), x1=(80,60), out_valid=1 for one cycle.
- W=−j (cos=0, sin=1024), same A/B -> x0=(90,30), x1=(110,70).
- W=−1 (cos=1024, sign=1), same A/B -> x0=(80,60), x1=(120,40).
- Rounding: cos=512, sin=0, A=0, B=(3,−3) -> x0=(2,−1), x1=(−2,1).
- Backpressure: 5 back-to-back beats, out_ready=0 for 4 cycles starting at first out_valid:
  - in_ready drops when the pipeline is full;
  - outputs are held stable;
  - all 5 results arrive in order with none lost.
- Reset pulse with 2 beats in flight -> out_valid=0 immediately; no stale output after release. With FFT_BFLY_SCALE_EN, case 1 yields x0=(60,20), x1=(40,30).
